rv32v_mem_lane_sequencer: RTL and testbench
===========================================

Name: rv32v_mem_lane_sequencer

Overview:
- Consumer of per-uop vector memory control from the vector decode/uop-generation stage: unit-stride, strided or indexed selects, EEW, uop number, lane-active mask.
- Per accepted uop, walks the active lanes in ascending order and issues one scalar data-bus request per lane.
- Collects load data, then presents a single lane-packed result to the vector writeback path.

Parameters:
- NUM_LANES, 2, elements processed per uop; element index = uop_num*NUM_LANES + lane.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- uop_valid  in  1  uop offered.
- uop_ready  out  1  sequencer can accept a uop.
- memdren  in  1  load uop.
- memdwen  in  1  store uop.
- unitstride / strided / indexed  in  1 each  addressing mode, one-hot.
- eew  in  2  0=SEW8, 1=SEW16, 2=SEW32.
- base  in  32  rs1 value.
- stride  in  32  rs2 value (byte stride).
- uop_num  in  8  uop number.
- lane_active  in  NUM_LANES  lane mask.
- index  in  NUM_LANES*32  per-lane unsigned byte offsets, already zero-extended.
- store_data  in  NUM_LANES*32  per-lane store elements, right-aligned.
- dmem_ren / dmem_wen  out  1  bus request.
- dmem_addr  out  32  byte address.
- dmem_wdata  out  32  write data.
- dmem_byte_en  out  4  byte enables.
- dmem_busy  in  1  request not yet complete.
- dmem_rdata  in  32  read data.
- result_valid  out  1  result available.
- result_ready  in  1  writeback accepts.
- result_data  out  NUM_LANES*32  per-lane load elements, zero-extended.
- result_misaligned  out  1  at least one lane was skipped as misaligned.

Behaviour:
- FSM states: IDLE, ACCESS, DONE. Reset: IDLE; all outputs 0 except uop_ready=1; latched data and flags cleared.
- IDLE:
  - uop_ready=1.
  - On uop_valid: latch all uop fields, clear result_data and the misaligned flag.
  - If lane_active==0, or neither memdren nor memdwen is set: go to DONE.
  - Otherwise go to ACCESS, with the lane pointer at the lowest active lane.
  - If memdren and memdwen are both set, the uop is treated as a load.
- ACCESS:
  - uop_ready=0.
  - Request is driven combinationally from the lane pointer and held stable until dmem_busy==0.
  - Exactly one of dmem_ren/dmem_wen is high.
- Element index e = uop_num*NUM_LANES + lane, 32-bit.
- Address, all arithmetic mod 2^32:
  - unit: base + (e << eew).
  - strided: base + e*stride, low 32 bits.
  - indexed: base + index[lane].
- Alignment, with off = addr[1:0]:
  - SEW16 requires addr[0]==0; SEW32 requires off==0.
  - A misaligned lane issues no bus request. It is skipped in the same cycle it is evaluated, sets the misaligned flag, and its result_data slot stays 0.
- Byte enables: SEW8 = 0001<<off; SEW16 = 0011<<off; SEW32 = 1111.
- Write data: element replicated across the word. SEW8 = byte x4, SEW16 = halfword x2, SEW32 = word.
- Completion: the request completes in the cycle dmem_busy==0 while a request is driven. The earliest completion is the first ACCESS cycle, so per-lane latency is at least 1 cycle.
  - On a load completion: result_data[lane] = dmem_rdata >> (8*off), masked to eew and zero-extended.
  - Then advance to the next higher active lane. If there is none, go to DONE.
- DONE:
  - result_valid=1; result_data and result_misaligned held stable.
  - On result_ready: go to IDLE. uop_ready rises the next cycle; there is no same-cycle accept.
  - Stores also produce a result_valid completion, with result_data=0.
- Inactive lanes are never accessed, and their result slot is 0.
- nRST asserted mid-operation: outputs drop asynchronously to reset values, the outstanding request is abandoned, and the FSM returns to IDLE.
- uop_valid is ignored outside IDLE. Upstream holds it (stalls) until uop_ready.

Test Plan:
- Unit-stride load: NUM_LANES=2, eew=SEW32, base=0x1000, uop_num=3, mask=11, busy=0 → addresses 0x1018 then 0x101C, 2 ACCESS cycles, result_valid on cycle 3.
- Strided SEW16 store: base=0x2000, stride=0x100, uop_num=1, mask=10, store_data[1]=0xABCD, busy=1 for 2 cycles → single request: addr 0x2300, byte_en 0011, wdata 0xABCDABCD held 3 cycles.
- Indexed SEW8 load:
  - Setup: base=0x3000, index={0x7,0x2}, mask=11.
  - rdata=0x44332211 at 0x3002 → lane0 = 0x33.
  - rdata=0x88776655 at 0x3007 → lane1 = 0x88.
  - byte_en 0100 then 1000.
- Misaligned/empty: SEW32 unit, base=0x1002 → no bus request, result_misaligned=1, data 0. mask=00 → DONE the cycle after accept, no request.
- Backpressure: result_ready=0 for 5 cycles → result held, uop_ready=0, new uop_valid ignored. After ready, a new uop is accepted the following cycle.
- Reset mid-access: nRST low while dmem_busy=1 → dmem_ren=0 immediately, uop_ready=1; after release, a fresh uop behaves normally.

Source files
------------

// File: rtl/rv32v_mem_lane_sequencer_if.sv
// Handshake and bus bundle between the vector uop source, the lane sequencer,
// the scalar data bus and the vector writeback path.
interface rv32v_mem_lane_sequencer_if #(
    parameter int NUM_LANES = 2
);
    logic                      uop_valid;
    logic                      uop_ready;
    logic                      memdren;
    logic                      memdwen;
    logic                      unitstride;
    logic                      strided;
    logic                      indexed;
    logic [1:0]                eew;
    logic [31:0]               base;
    logic [31:0]               stride;
    logic [7:0]                uop_num;
    logic [NUM_LANES-1:0]      lane_active;
    logic [NUM_LANES*32-1:0]   index;
    logic [NUM_LANES*32-1:0]   store_data;

    logic                      dmem_ren;
    logic                      dmem_wen;
    logic [31:0]               dmem_addr;
    logic [31:0]               dmem_wdata;
    logic [3:0]                dmem_byte_en;
    logic                      dmem_busy;
    logic [31:0]               dmem_rdata;

    logic                      result_valid;
    logic                      result_ready;
    logic [NUM_LANES*32-1:0]   result_data;
    logic                      result_misaligned;

    modport master (
        output uop_valid, memdren, memdwen, unitstride, strided, indexed,
               eew, base, stride, uop_num, lane_active, index, store_data,
               dmem_busy, dmem_rdata, result_ready,
        input  uop_ready, dmem_ren, dmem_wen, dmem_addr, dmem_wdata, dmem_byte_en,
               result_valid, result_data, result_misaligned
    );

    modport slave (
        input  uop_valid, memdren, memdwen, unitstride, strided, indexed,
               eew, base, stride, uop_num, lane_active, index, store_data,
               dmem_busy, dmem_rdata, result_ready,
        output uop_ready, dmem_ren, dmem_wen, dmem_addr, dmem_wdata, dmem_byte_en,
               result_valid, result_data, result_misaligned
    );
endinterface

// File: rtl/rv32v_mem_lane_sequencer.sv
// Walks the active lanes of one vector memory uop, one scalar bus request per lane.
// Latency: accept cycle + (1 + busy cycles) per aligned lane + 1 per misaligned lane, then DONE.
// Backpressure: uop_ready only in IDLE; requests held while dmem_busy; result held until result_ready.
module rv32v_mem_lane_sequencer #(
    parameter int NUM_LANES = 2
) (
    input  logic                       CLK,
    input  logic                       nRST,
    rv32v_mem_lane_sequencer_if.slave  bus
);
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                  state;
    logic                    is_load;
    logic                    misal_q;
    logic [2:0]              mode_q;
    logic [1:0]              eew_q;
    logic [31:0]             base_q;
    logic [31:0]             stride_q;
    logic [7:0]              uop_num_q;
    logic [NUM_LANES-1:0]    mask_q;
    logic [NUM_LANES*32-1:0] index_q;
    logic [NUM_LANES*32-1:0] store_q;
    logic [NUM_LANES*32-1:0] result_q;
    logic [LW-1:0]           lane_q;

    logic [LW-1:0]           first_lane;
    logic [LW-1:0]           next_lane;
    logic                    has_next;
    logic [31:0]             elem;
    logic [31:0]             addr;
    logic [31:0]             lane_index;
    logic [31:0]             lane_store;
    logic [31:0]             rd_shift;
    logic [31:0]             load_val;
    logic [31:0]             wdata;
    logic [3:0]              byte_en;
    logic [1:0]              off;
    logic                    misal;
    logic                    req;
    logic                    lane_done;

    // Descending scan so the last hit is the lowest qualifying lane.
    always_comb begin
        first_lane = '0;
        next_lane  = '0;
        has_next   = 1'b0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (bus.lane_active[i]) first_lane = LW'(i);
            if (mask_q[i] && (i > int'(lane_q))) begin
                next_lane = LW'(i);
                has_next  = 1'b1;
            end
        end
    end

    always_comb begin
        elem       = 32'(uop_num_q) * 32'(NUM_LANES) + 32'(lane_q);
        lane_index = index_q[int'(lane_q)*32 +: 32];
        lane_store = store_q[int'(lane_q)*32 +: 32];
        case (mode_q)
            3'b010:  addr = base_q + elem * stride_q;
            3'b100:  addr = base_q + lane_index;
            default: addr = base_q + (elem << eew_q);
        endcase
        off      = addr[1:0];
        rd_shift = bus.dmem_rdata >> {off, 3'b000};
        case (eew_q)
            2'd0: begin
                misal    = 1'b0;
                byte_en  = 4'b0001 << off;
                wdata    = {4{lane_store[7:0]}};
                load_val = {24'b0, rd_shift[7:0]};
            end
            2'd1: begin
                misal    = off[0];
                byte_en  = 4'b0011 << off;
                wdata    = {2{lane_store[15:0]}};
                load_val = {16'b0, rd_shift[15:0]};
            end
            default: begin
                misal    = (off != 2'd0);
                byte_en  = 4'b1111;
                wdata    = lane_store;
                load_val = rd_shift;
            end
        endcase
        req       = (state == ACCESS) && !misal;
        lane_done = (state == ACCESS) && (misal || !bus.dmem_busy);
    end

    assign bus.uop_ready         = (state == IDLE);
    assign bus.dmem_ren          = req && is_load;
    assign bus.dmem_wen          = req && !is_load;
    assign bus.dmem_addr         = req ? addr    : 32'b0;
    assign bus.dmem_wdata        = req ? wdata   : 32'b0;
    assign bus.dmem_byte_en      = req ? byte_en : 4'b0;
    assign bus.result_valid      = (state == DONE);
    assign bus.result_data       = result_q;
    assign bus.result_misaligned = misal_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            is_load   <= 1'b0;
            misal_q   <= 1'b0;
            mode_q    <= '0;
            eew_q     <= '0;
            base_q    <= '0;
            stride_q  <= '0;
            uop_num_q <= '0;
            mask_q    <= '0;
            index_q   <= '0;
            store_q   <= '0;
            result_q  <= '0;
            lane_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.uop_valid) begin
                        is_load   <= bus.memdren;
                        mode_q    <= {bus.indexed, bus.strided, bus.unitstride};
                        eew_q     <= bus.eew;
                        base_q    <= bus.base;
                        stride_q  <= bus.stride;
                        uop_num_q <= bus.uop_num;
                        mask_q    <= bus.lane_active;
                        index_q   <= bus.index;
                        store_q   <= bus.store_data;
                        result_q  <= '0;
                        misal_q   <= 1'b0;
                        lane_q    <= first_lane;
                        if ((bus.lane_active == '0) || !(bus.memdren || bus.memdwen))
                            state <= DONE;
                        else
                            state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (lane_done) begin
                        if (misal)
                            misal_q <= 1'b1;
                        else if (is_load)
                            result_q[int'(lane_q)*32 +: 32] <= load_val;
                        if (has_next)
                            lane_q <= next_lane;
                        else
                            state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.result_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rv32v_mem_lane_sequencer.sv
// Bench for the vector memory lane sequencer: a per-uop cycle trace is derived from
// address/alignment arithmetic and compared against the DUT every cycle.
module tb_rv32v_mem_lane_sequencer;
    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    rv32v_mem_lane_sequencer_if #(.NUM_LANES(2)) bus();
    rv32v_mem_lane_sequencer #(.NUM_LANES(2)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

    typedef struct packed {
        logic            ren;
        logic            wen;
        logic [2:0]      mode;   // {indexed, strided, unitstride}
        logic [1:0]      eew;
        logic [31:0]     base;
        logic [31:0]     stride;
        logic [7:0]      num;
        logic [1:0]      mask;
        logic [1:0][31:0] idx;
        logic [1:0][31:0] st;
    } uop_t;

    typedef struct packed {
        logic        urdy;
        logic        ren;
        logic        wen;
        logic        rvld;
        logic        mis;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [63:0] rdat;
    } exp_t;

    exp_t exp_q[$];
    exp_t cmp_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
        end
    endtask

    function automatic int esz(input uop_t u);
        return 1 << u.eew;
    endfunction

    function automatic logic [31:0] lane_addr(input uop_t u, input int l);
        logic [31:0] e;
        e = 32'(u.num) * 32'd2 + 32'(l);
        case (u.mode)
            3'b010:  return u.base + e * u.stride;
            3'b100:  return u.base + u.idx[l];
            default: return u.base + e * 32'(esz(u));
        endcase
    endfunction

    function automatic bit lane_mis(input uop_t u, input int l);
        logic [31:0] a;
        a = lane_addr(u, l);
        return (int'(a[1:0]) % esz(u)) != 0;
    endfunction

    function automatic logic [3:0] lane_be(input uop_t u, input int l);
        logic [31:0] a;
        logic [3:0]  be;
        int          off;
        a   = lane_addr(u, l);
        off = int'(a[1:0]);
        be  = '0;
        for (int b = 0; b < esz(u); b++)
            if (off + b < 4) be[off + b] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] lane_wd(input uop_t u, input int l);
        logic [31:0] s;
        logic [31:0] w;
        s = u.st[l];
        w = '0;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = s[8*(b % esz(u)) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] ld_val(input logic [31:0] rd, input logic [31:0] a, input int sz);
        logic [63:0] v;
        logic [63:0] m;
        v = {32'b0, rd} >> (8 * int'(a[1:0]));
        m = (64'd1 << (8 * sz)) - 64'd1;
        return 32'(v & m);
    endfunction

    function automatic uop_t rand_uop();
        uop_t u;
        int   m;
        m        = int'($urandom % 10);
        u.ren    = (m < 5) || (m == 8);
        u.wen    = (m >= 5) && (m <= 8);
        u.mode   = 3'b001 << ($urandom % 3);
        u.eew    = 2'($urandom % 3);
        u.base   = $urandom;
        if ($urandom % 4 != 0) u.base[1:0] = 2'b00;
        u.stride = $urandom % 256;
        if ($urandom % 4 != 0) u.stride[1:0] = 2'b00;
        u.num    = 8'($urandom);
        u.mask   = 2'($urandom);
        u.idx[0] = $urandom % 64;
        u.idx[1] = $urandom % 64;
        u.st[0]  = $urandom;
        u.st[1]  = $urandom;
        return u;
    endfunction

    task automatic drive_uop(input uop_t u, input logic v);
        bus.uop_valid   = v;
        bus.memdren     = u.ren;
        bus.memdwen     = u.wen;
        bus.indexed     = u.mode[2];
        bus.strided     = u.mode[1];
        bus.unitstride  = u.mode[0];
        bus.eew         = u.eew;
        bus.base        = u.base;
        bus.stride      = u.stride;
        bus.uop_num     = u.num;
        bus.lane_active = u.mask;
        bus.index       = u.idx;
        bus.store_data  = u.st;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic noise_in(input bit noise);
        if (noise) begin
            drive_uop(rand_uop(), 1'($urandom % 2));
            bus.result_ready = 1'($urandom % 2);
        end else begin
            bus.uop_valid = 1'b0;
        end
    endtask

    // Expected trace: accept cycle, then each active lane in order, then DONE until result_ready.
    task automatic run_uop(input uop_t u, input int busy0, input int busy1, input int rwait, input bit noise);
        exp_t        e;
        logic [63:0] res;
        logic [31:0] a;
        logic [31:0] rd;
        bit          anymis;
        bit          noop;
        int          bz;
        res    = '0;
        anymis = 1'b0;
        noop   = (u.mask == 2'b00) || !(u.ren || u.wen);
        drive_uop(u, 1'b1);
        bus.result_ready = 1'b0;
        bus.dmem_busy    = 1'b0;
        bus.dmem_rdata   = $urandom;
        e = '0; e.urdy = 1'b1; exp_q.push_back(e);
        step();
        noise_in(noise);
        if (!noop) begin
            for (int l = 0; l < 2; l++) begin
                if (u.mask[l]) begin
                    a = lane_addr(u, l);
                    if (lane_mis(u, l)) begin
                        anymis = 1'b1;
                        e = '0; exp_q.push_back(e);
                        step();
                        noise_in(noise);
                    end else begin
                        bz = (l == 0) ? busy0 : busy1;
                        rd = $urandom;
                        if (u.ren) res[32*l +: 32] = ld_val(rd, a, esz(u));
                        for (int c = 0; c <= bz; c++) begin
                            bus.dmem_busy  = (c < bz);
                            bus.dmem_rdata = (c < bz) ? $urandom : rd;
                            e = '0;
                            e.ren = u.ren; e.wen = !u.ren;
                            e.addr = a; e.be = lane_be(u, l); e.wdata = lane_wd(u, l);
                            exp_q.push_back(e);
                            step();
                            noise_in(noise);
                        end
                    end
                end
            end
        end
        bus.dmem_busy = 1'b0;
        for (int c = 0; c <= rwait; c++) begin
            bus.result_ready = (c == rwait);
            e = '0; e.rvld = 1'b1; e.rdat = res; e.mis = anymis;
            exp_q.push_back(e);
            step();
            noise_in(noise);
        end
        bus.result_ready = 1'b0;
        bus.uop_valid    = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            cmp_e = exp_q.pop_front();
            chk("uop_ready", 64'(bus.uop_ready), 64'(cmp_e.urdy));
            chk("dmem_ren", 64'(bus.dmem_ren), 64'(cmp_e.ren));
            chk("dmem_wen", 64'(bus.dmem_wen), 64'(cmp_e.wen));
            chk("result_valid", 64'(bus.result_valid), 64'(cmp_e.rvld));
            if (cmp_e.ren || cmp_e.wen) begin
                chk("dmem_addr", 64'(bus.dmem_addr), 64'(cmp_e.addr));
                chk("dmem_byte_en", 64'(bus.dmem_byte_en), 64'(cmp_e.be));
            end
            if (cmp_e.wen) chk("dmem_wdata", 64'(bus.dmem_wdata), 64'(cmp_e.wdata));
            if (cmp_e.rvld) begin
                chk("result_data", bus.result_data, cmp_e.rdat);
                chk("result_misaligned", 64'(bus.result_misaligned), 64'(cmp_e.mis));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        uop_t u;
        exp_t e;
        nRST = 1'b0;
        u = '0;
        drive_uop(u, 1'b0);
        bus.result_ready = 1'b0;
        bus.dmem_busy    = 1'b0;
        bus.dmem_rdata   = '0;
        #2;
        chk("reset uop_ready", 64'(bus.uop_ready), 64'd1);
        chk("reset dmem_ren", 64'(bus.dmem_ren), 64'd0);
        chk("reset dmem_wen", 64'(bus.dmem_wen), 64'd0);
        chk("reset result_valid", 64'(bus.result_valid), 64'd0);
        chk("reset result_data", bus.result_data, 64'd0);
        chk("reset result_misaligned", 64'(bus.result_misaligned), 64'd0);

        // Hand-computed points pinning the model arithmetic.
        u = '0; u.ren = 1; u.mode = 3'b001; u.eew = 2; u.base = 32'h1000; u.num = 3; u.mask = 2'b11;
        chk("model unit lane0 addr", 64'(lane_addr(u, 0)), 64'h1018);
        chk("model unit lane1 addr", 64'(lane_addr(u, 1)), 64'h101C);
        u.base = 32'h1002;
        chk("model sew32 misaligned", 64'(lane_mis(u, 0)), 64'd1);
        u = '0; u.wen = 1; u.mode = 3'b010; u.eew = 1; u.base = 32'h2000; u.stride = 32'h100;
        u.num = 1; u.mask = 2'b10; u.st[1] = 32'h0000ABCD;
        chk("model strided addr", 64'(lane_addr(u, 1)), 64'h2300);
        chk("model strided be", 64'(lane_be(u, 1)), 64'b0011);
        chk("model strided wdata", 64'(lane_wd(u, 1)), 64'hABCDABCD);
        u = '0; u.ren = 1; u.mode = 3'b100; u.eew = 0; u.base = 32'h3000; u.mask = 2'b11;
        u.idx[0] = 32'h2; u.idx[1] = 32'h7;
        chk("model indexed be0", 64'(lane_be(u, 0)), 64'b0100);
        chk("model indexed be1", 64'(lane_be(u, 1)), 64'b1000);
        chk("model indexed ld0", 64'(ld_val(32'h44332211, lane_addr(u, 0), 1)), 64'h33);
        chk("model indexed ld1", 64'(ld_val(32'h88776655, lane_addr(u, 1), 1)), 64'h88);

        @(negedge CLK);
        nRST = 1'b1;
        step();

        u = '0; u.ren = 1; u.mode = 3'b001; u.eew = 2; u.base = 32'h1000; u.num = 3; u.mask = 2'b11;
        run_uop(u, 0, 0, 0, 1'b0);
        u = '0; u.wen = 1; u.mode = 3'b010; u.eew = 1; u.base = 32'h2000; u.stride = 32'h100;
        u.num = 1; u.mask = 2'b10; u.st[1] = 32'h0000ABCD; u.st[0] = 32'h12345678;
        run_uop(u, 0, 2, 0, 1'b0);
        u = '0; u.ren = 1; u.mode = 3'b100; u.eew = 0; u.base = 32'h3000; u.mask = 2'b11;
        u.idx[0] = 32'h2; u.idx[1] = 32'h7;
        run_uop(u, 1, 0, 0, 1'b0);
        u = '0; u.ren = 1; u.mode = 3'b001; u.eew = 2; u.base = 32'h1002; u.mask = 2'b11;
        run_uop(u, 0, 0, 0, 1'b0);
        u.base = 32'h1000; u.mask = 2'b00;
        run_uop(u, 0, 0, 0, 1'b0);
        u.mask = 2'b11; u.num = 8'h10;
        run_uop(u, 0, 1, 5, 1'b1);
        run_uop(rand_uop(), 0, 0, 0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom % 5 == 0) begin
                bus.uop_valid = 1'b0;
                e = '0; e.urdy = 1'b1; exp_q.push_back(e);
                step();
            end
            run_uop(rand_uop(), int'($urandom % 4), int'($urandom % 4), int'($urandom % 4), 1'($urandom % 2));
        end

        // Reset while a request is stalled on dmem_busy.
        u = '0; u.ren = 1; u.mode = 3'b001; u.eew = 2; u.base = 32'h4000; u.num = 2; u.mask = 2'b01;
        drive_uop(u, 1'b1);
        bus.dmem_busy = 1'b1;
        e = '0; e.urdy = 1'b1; exp_q.push_back(e);
        step();
        bus.uop_valid = 1'b0;
        e = '0; e.ren = 1'b1; e.addr = lane_addr(u, 0); e.be = 4'b1111; exp_q.push_back(e);
        step();
        #2;
        nRST = 1'b0;
        #1;
        chk("mid-reset dmem_ren", 64'(bus.dmem_ren), 64'd0);
        chk("mid-reset uop_ready", 64'(bus.uop_ready), 64'd1);
        chk("mid-reset result_valid", 64'(bus.result_valid), 64'd0);
        @(negedge CLK);
        #1;
        nRST = 1'b1;
        bus.dmem_busy = 1'b0;
        step();
        u.mask = 2'b11;
        run_uop(u, 1, 2, 1, 1'b0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
